noc_inject_arbiter: RTL and testbench

- Shares one router injection port among NUM_REQ flit sources (e.g. several AXI-stream-to-NoC adapters) using packet-atomic round-robin arbitration.
- Owns the credit-based flow control toward the router input buffer; drives the 36-bit router channel {valid, ctrl[2:0], data[31:0]}.
- Sits between the adapters and the router_slice injection port (port 4).

---
 rtl/noc_inject_pkg.sv | 24 ++
 rtl/noc_rr_picker.sv | 30 +++
 rtl/noc_inject_arbiter.sv | 167 ++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_inject_pkg.sv
// Shared definitions for the NoC injection arbiter: flit field positions, ctrl encodings, FSM states.
package noc_inject_pkg;

  localparam int unsigned VALID_BIT = 35;
  localparam int unsigned CTRL_MSB  = 34;
  localparam int unsigned CTRL_LSB  = 32;
  localparam int unsigned HEAD_BIT  = 34;
  localparam int unsigned TAIL_BIT  = 33;

  // Bit positions inside the 3-bit ctrl field
  localparam int unsigned CTRL_HEAD_IDX = 2;
  localparam int unsigned CTRL_TAIL_IDX = 1;

  localparam logic [2:0] CTRL_SINGLE = 3'b110;
  localparam logic [2:0] CTRL_HEAD   = 3'b100;
  localparam logic [2:0] CTRL_BODY   = 3'b000;
  localparam logic [2:0] CTRL_TAIL   = 3'b010;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } state_e;

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after i_ptr, searching circularly.
module noc_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);

  logic [PTR_W-1:0] w_j;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_j     = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_elig[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin injection arbiter with credit flow control toward one router port.
// Optional per-requester/stall statistics when NOC_INJECT_ARB_STATS_EN is defined.
module noc_inject_arbiter
  import noc_inject_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned CRED_W    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*(DATA_W+3)-1:0]  i_req_flit,
  output logic [DATA_W+3:0]              o_channel_out,
  input  logic                           i_flow_ctrl_in,
  output logic [CRED_W-1:0]              o_credit_count,
  output logic                           o_busy,
  output logic                           o_error
`ifdef NOC_INJECT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          o_stat_flits,
  output logic [15:0]                    o_stat_stall
`endif
);

  localparam int unsigned FLIT_W = DATA_W + 3;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_e              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]    r_owner, w_owner_nxt;
  logic [CRED_W-1:0]   r_credit, w_credit_nxt;
  logic                r_error, w_error_set;
  logic [DATA_W+3:0]   r_channel, w_channel_nxt;

  logic [NUM_REQ-1:0]  w_head, w_tail, w_elig;
  logic [NUM_REQ-1:0]  w_pick_grant, w_grant, w_ready;
  logic [PTR_W-1:0]    w_pick_idx, w_sel_idx, w_sel_inc;
  logic [FLIT_W-1:0]   w_sel_flit;
  logic                w_has_credit, w_send, w_sel_head, w_sel_tail, w_at_max;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fields
    assign w_head[gi] = i_req_flit[gi*FLIT_W + DATA_W + CTRL_HEAD_IDX];
    assign w_tail[gi] = i_req_flit[gi*FLIT_W + DATA_W + CTRL_TAIL_IDX];
  end

  assign w_elig = i_req_valid & w_head;

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  assign w_has_credit = (r_credit != '0);
  assign w_at_max     = (r_credit == CRED_MAX);

  always_comb begin
    w_grant = '0;
    if (r_state == LOCKED) begin
      w_grant[r_owner] = 1'b1;
    end else begin
      w_grant = w_pick_grant;
    end
  end

  assign w_sel_idx  = (r_state == LOCKED) ? r_owner : w_pick_idx;
  assign w_sel_inc  = (w_sel_idx == PTR_LAST) ? '0 : w_sel_idx + 1'b1;
  assign w_sel_flit = i_req_flit[w_sel_idx*FLIT_W +: FLIT_W];
  assign w_sel_head = w_sel_flit[DATA_W + CTRL_HEAD_IDX];
  assign w_sel_tail = w_sel_flit[DATA_W + CTRL_TAIL_IDX];

  // Gated by reset so ready reads 0 while reset is held, not just after the first edge
  assign w_ready     = w_grant & {NUM_REQ{w_has_credit & i_rst_n}};
  assign o_req_ready = w_ready;
  assign w_send      = |(w_ready & i_req_valid);

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_error_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|(i_req_valid & ~w_head)) w_error_set = 1'b1;
        if (w_send) begin
          if (w_sel_tail) begin
            w_rr_ptr_nxt = w_sel_inc;
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_sel_idx;
          end
        end
      end
      LOCKED: begin
        if (w_send && w_sel_head) w_error_set = 1'b1;
        if (w_send && w_sel_tail) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_sel_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_flow_ctrl_in && !w_send && w_at_max) w_error_set = 1'b1;
  end

  always_comb begin
    w_credit_nxt = r_credit;
    if (w_send && !i_flow_ctrl_in) begin
      w_credit_nxt = r_credit - 1'b1;
    end else if (!w_send && i_flow_ctrl_in && !w_at_max) begin
      w_credit_nxt = r_credit + 1'b1;
    end
  end

  assign w_channel_nxt = w_send ? {1'b1, w_sel_flit} : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_credit  <= CRED_MAX;
      r_error   <= 1'b0;
      r_channel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_credit  <= w_credit_nxt;
      r_error   <= r_error | w_error_set;
      r_channel <= w_channel_nxt;
    end
  end

  assign o_channel_out  = r_channel;
  assign o_credit_count = r_credit;
  assign o_busy         = (r_state == LOCKED);
  assign o_error        = r_error;

`ifdef NOC_INJECT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stat_flits;
  logic [15:0]              r_stat_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_flits <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_send) r_stat_flits[w_sel_idx] <= r_stat_flits[w_sel_idx] + 16'd1;
      if (|i_req_valid && !w_has_credit) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign o_stat_flits = r_stat_flits;
  assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomized and directed bench for noc_inject_arbiter against a packet-level reference model.
module tb_noc_inject_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    tb_valid;
  logic [34:0]     tb_flit [N];
  logic            tb_ret;
  logic [N-1:0]    dut_ready;
  logic [35:0]     dut_chan;
  logic [3:0]      dut_cred;
  logic            dut_busy;
  logic            dut_err;
  logic [N*35-1:0] flit_bus;

`ifdef NOC_INJECT_ARB_STATS_EN
  logic [N*16-1:0] stat_flits;
  logic [15:0]     stat_stall;
`endif

  assign flit_bus = {tb_flit[3], tb_flit[2], tb_flit[1], tb_flit[0]};

  noc_inject_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (32),
    .BUF_DEPTH (DEPTH),
    .CRED_W    (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (tb_valid),
    .o_req_ready    (dut_ready),
    .i_req_flit     (flit_bus),
    .o_channel_out  (dut_chan),
    .i_flow_ctrl_in (tb_ret),
    .o_credit_count (dut_cred),
    .o_busy         (dut_busy),
    .o_error        (dut_err)
`ifdef NOC_INJECT_ARB_STATS_EN
    ,
    .o_stat_flits   (stat_flits),
    .o_stat_stall   (stat_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet-level view of lock ownership, pointer and credits
  bit          m_locked;
  int          m_owner, m_rr, m_cred, m_win;
  bit          m_err, m_send;
  logic [N-1:0] m_ready;
  logic [35:0] m_chan;
  logic [N-1:0] seen_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] mk(input bit h, input bit t, input logic [31:0] d);
    return {h, t, 1'($urandom_range(0, 1)), d};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_cred = DEPTH; m_err = 0; m_chan = '0;
    m_send = 0; m_win = -1;
  endtask

  task automatic model_comb();
    m_win = -1;
    if (m_locked) m_win = m_owner;
    else
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (m_win < 0 && tb_valid[j] && tb_flit[j][34]) m_win = j;
      end
    m_ready = '0;
    if (m_win >= 0 && m_cred > 0) m_ready[m_win] = 1'b1;
    m_send = (m_win >= 0) && (m_cred > 0) && tb_valid[m_win];
  endtask

  task automatic model_update();
    if (!m_locked)
      for (int i = 0; i < N; i++) if (tb_valid[i] && !tb_flit[i][34]) m_err = 1;
    if (m_locked && m_send && tb_flit[m_win][34]) m_err = 1;
    if (tb_ret && !m_send && m_cred == DEPTH) m_err = 1;
    m_chan = m_send ? {1'b1, tb_flit[m_win]} : 36'h0;
    m_cred = m_cred + (tb_ret ? 1 : 0) - (m_send ? 1 : 0);
    if (m_cred > DEPTH) m_cred = DEPTH;
    if (m_send) begin
      if (tb_flit[m_win][33]) begin
        m_locked = 0;
        m_rr = (m_win + 1) % N;
      end else begin
        m_locked = 1;
        m_owner = m_win;
      end
    end
  endtask

  // One clock: inputs already driven at the negedge; returns at the next negedge
  task automatic cycle();
    #1;
    model_comb();
    seen_ready = dut_ready;
    chk("req_ready", dut_ready, m_ready);
    @(posedge clk);
    #1;
    model_update();
    chk("channel_out", dut_chan, m_chan);
    chk("credit_count", dut_cred, 64'(m_cred));
    chk("busy", dut_busy, m_locked);
    chk("error", dut_err, m_err);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_channel", dut_chan, 36'h0);
    chk("rst_credit", dut_cred, 4'd8);
    chk("rst_busy", dut_busy, 1'b0);
    chk("rst_error", dut_err, 1'b0);
    chk("rst_ready", dut_ready, 4'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_credit", dut_cred, 4'd8);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    tb_valid = '0;
    tb_ret   = 1'b0;
    for (int i = 0; i < N; i++) tb_flit[i] = '0;
  endtask

  int         left [N];
  logic [34:0] cur [N];
  int         sent_cnt;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Randomized traffic, two return-rate phases to exercise credit exhaustion
    for (int i = 0; i < N; i++) begin left[i] = 0; cur[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int rate;
      rate = (cyc < 1500) ? 15 : 70;
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && ($urandom % 4) == 0) begin
          left[i] = $urandom_range(1, 4);
          cur[i]  = mk(1, left[i] == 1, $urandom);
        end
        tb_valid[i] = (left[i] > 0) && (($urandom % 4) != 0);
        tb_flit[i]  = cur[i];
      end
      tb_ret = (m_cred < DEPTH) && (($urandom % 100) < rate);
      cycle();
      if (m_send) begin
        left[m_win]--;
        if (left[m_win] > 0) cur[m_win] = mk(0, left[m_win] == 1, $urandom);
      end
    end
    idle_inputs();

    // Single-flit packet
    do_reset();
    tb_valid = 4'b0001;
    tb_flit[0] = {3'b110, 32'hAABBCCDD};
    cycle();
    chk("single_ready", seen_ready, 4'b0001);
    chk("single_chan", dut_chan, 36'hE_AABBCCDD);
    chk("single_cred", dut_cred, 4'd7);

    // Round-robin from pointer 0
    do_reset();
    idle_inputs();
    tb_valid = 4'b0110;
    tb_flit[1] = {3'b110, 32'h11111111};
    tb_flit[2] = {3'b110, 32'h22222222};
    cycle();
    chk("rr_first", seen_ready, 4'b0010);
    chk("rr_first_chan", dut_chan, 36'hE_11111111);
    tb_valid = 4'b0100;
    cycle();
    chk("rr_second", seen_ready, 4'b0100);
    tb_valid = 4'b1001;
    tb_flit[0] = {3'b110, 32'h0};
    tb_flit[3] = {3'b110, 32'h33333333};
    cycle();
    chk("rr_ptr_at_3", seen_ready, 4'b1000);

    // Packet lock with a competing head flit and an owner idle cycle
    do_reset();
    idle_inputs();
    tb_valid = 4'b0011;
    tb_flit[0] = {3'b100, 32'hA0};
    tb_flit[1] = {3'b110, 32'hB0};
    cycle();
    chk("lock_head", seen_ready, 4'b0001);
    chk("lock_busy", dut_busy, 1'b1);
    tb_valid = 4'b0010;
    cycle();
    chk("lock_idle_owner", seen_ready, 4'b0001);
    chk("lock_idle_chan", dut_chan, 36'h0);
    tb_valid = 4'b0011;
    tb_flit[0] = {3'b000, 32'hA1};
    cycle();
    chk("lock_body", seen_ready, 4'b0001);
    chk("lock_body_busy", dut_busy, 1'b1);
    tb_flit[0] = {3'b010, 32'hA2};
    cycle();
    chk("lock_tail", seen_ready, 4'b0001);
    chk("lock_release", dut_busy, 1'b0);
    tb_valid = 4'b0010;
    cycle();
    chk("lock_next", seen_ready, 4'b0010);
    chk("lock_next_chan", dut_chan, 36'hE_000000B0);

    // Credit exhaustion and return timing
    do_reset();
    idle_inputs();
    tb_valid = 4'b1000;
    tb_flit[3] = {3'b110, 32'hC0};
    sent_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (dut_chan[35]) sent_cnt++;
    end
    chk("exh_count", 64'(sent_cnt), 64'd8);
    chk("exh_cred", dut_cred, 4'd0);
    tb_ret = 1'b1;
    cycle();
    chk("exh_ret_same", seen_ready, 4'b0000);
    chk("exh_ret_cred", dut_cred, 4'd1);
    tb_ret = 1'b0;
    cycle();
    chk("exh_resume", seen_ready, 4'b1000);
    chk("exh_resume_chan", dut_chan[35], 1'b1);

    // Simultaneous send/return, then overflow return
    do_reset();
    idle_inputs();
    tb_valid = 4'b1000;
    tb_flit[3] = {3'b110, 32'hD0};
    repeat (3) cycle();
    chk("cred5", dut_cred, 4'd5);
    tb_ret = 1'b1;
    cycle();
    chk("cred5_both", dut_cred, 4'd5);
    tb_valid = '0;
    repeat (3) cycle();
    chk("cred8", dut_cred, 4'd8);
    chk("cred8_noerr", dut_err, 1'b0);
    cycle();
    chk("cred_sat", dut_cred, 4'd8);
    chk("cred_ovf_err", dut_err, 1'b1);

    // Non-head flit in IDLE, then head flit while locked
    do_reset();
    idle_inputs();
    tb_valid = 4'b0001;
    tb_flit[0] = {3'b000, 32'hE0};
    cycle();
    chk("nohead_ready", seen_ready, 4'b0000);
    chk("nohead_err", dut_err, 1'b1);
    do_reset();
    tb_flit[0] = {3'b100, 32'hE1};
    cycle();
    cycle();
    chk("dbl_head_err", dut_err, 1'b1);
    chk("dbl_head_fwd", dut_chan, 36'hC_000000E1);

    // Reset asserted mid-packet (do_reset checks outputs before any clock edge)
    do_reset();
    tb_valid = 4'b0001;
    tb_flit[0] = {3'b100, 32'hF0};
    cycle();
    chk("mid_busy", dut_busy, 1'b1);
    tb_flit[0] = {3'b000, 32'hF1};
    do_reset();
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
